// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: WB register, load formatting, register file write port (optional macro WB_INSTRET_EN adds instret_o)
module wb_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_rd_wren_i,
    input  logic [4:0]  mem_rd_addr_i,
    input  logic [1:0]  mem_wb_sel_i,
    input  logic [31:0] mem_alu_data_i,
    input  logic [31:0] mem_ld_data_i,
    input  logic [2:0]  mem_ld_funct3_i,
    input  logic [1:0]  mem_addr_lo_i,
    output logic        rd_wren,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        wb_valid_o,
    output logic [31:0] wb_pc_o
`ifdef WB_INSTRET_EN
    , output logic [63:0] instret_o
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } wb_state_t;

    wb_state_t   state_q, state_d;
    logic [31:0] pc_q;
    logic        rd_wren_q;
    logic [4:0]  rd_addr_q;
    logic [1:0]  wb_sel_q;
    logic [31:0] alu_data_q;
    logic [31:0] ld_data_q;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] ld_fmt;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        capture;

    // Flush beats stall; reset is handled separately and beats both.
    assign capture = !flush_i && !stall_i;

    // State register: EMPTY holds a bubble, HOLD a real instruction.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: flush empties, stall holds, capture follows mem_valid_i.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else if (!stall_i) begin
            state_d = mem_valid_i ? HOLD : EMPTY;
        end
    end

    // Payload fields; a flushed entry keeps stale payload since valid is cleared.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q       <= RESET_PC;
            rd_wren_q  <= 1'b0;
            rd_addr_q  <= 5'd0;
            wb_sel_q   <= 2'd0;
            alu_data_q <= 32'd0;
            ld_data_q  <= 32'd0;
            funct3_q   <= 3'd0;
            addr_lo_q  <= 2'd0;
        end else if (capture) begin
            pc_q       <= mem_pc_i;
            rd_wren_q  <= mem_rd_wren_i;
            rd_addr_q  <= mem_rd_addr_i;
            wb_sel_q   <= mem_wb_sel_i;
            alu_data_q <= mem_alu_data_i;
            ld_data_q  <= mem_ld_data_i;
            funct3_q   <= mem_ld_funct3_i;
            addr_lo_q  <= mem_addr_lo_i;
        end
    end

    // Lane extraction and sign/zero extension of the loaded word.
    always_comb begin
        ld_byte = ld_data_q[7:0];
        case (addr_lo_q)
            2'd0: ld_byte = ld_data_q[7:0];
            2'd1: ld_byte = ld_data_q[15:8];
            2'd2: ld_byte = ld_data_q[23:16];
            2'd3: ld_byte = ld_data_q[31:24];
            default: ld_byte = ld_data_q[7:0];
        endcase
        ld_half = addr_lo_q[1] ? ld_data_q[31:16] : ld_data_q[15:0];
        ld_fmt  = ld_data_q;
        case (funct3_q)
            3'b000: ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b100: ld_fmt = {24'd0, ld_byte};
            3'b001: ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'b101: ld_fmt = {16'd0, ld_half};
            default: ld_fmt = ld_data_q;
        endcase
    end

    // Writeback source select; PC+4 wraps naturally at 32 bits.
    always_comb begin
        rd_data = alu_data_q;
        case (wb_sel_q)
            2'b01: rd_data = ld_fmt;
            2'b10: rd_data = pc_q + 32'd4;
            default: rd_data = alu_data_q;
        endcase
    end

    // x0 must never be written: the register file bypasses writes to its read ports.
    assign rd_wren    = (state_q == HOLD) && rd_wren_q && (rd_addr_q != 5'd0);
    assign rd_addr    = rd_addr_q;
    assign wb_valid_o = (state_q == HOLD);
    assign wb_pc_o    = pc_q;

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q;

    // Retire counter: counts only edges that capture a valid instruction.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instret_q <= 64'd0;
        end else if (capture && mem_valid_i) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instret_o = instret_q;
`endif

endmodule
